pr_bridge: RTL

Sequencing controller between the MEM stage's peripheral port and the memory-mapped I/O devices. It decodes peripheral-space accesses (address ≥ 0x7f00), drives a registered select/acknowledge handshake toward one of two devices, and holds the pipeline with a stall until the transfer completes. Unresponsive devices are terminated by a timeout, unmapped addresses are reported, and device interrupt requests are registered for the CP0 hardware-interrupt inputs.

---
 rtl/pr_bridge_if.sv | 40 ++++
 rtl/pr_bridge.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pr_bridge_if.sv
// Bus bundle between the MEM-stage peripheral port, the bridge, and the two I/O devices.
// The slave modport is the bridge's view; the master modport is the view of the CPU and devices.
interface pr_bridge_if;
  logic [31:0] PrAddr;
  logic [31:0] PrWData;
  logic [3:0]  PrMask;
  logic        PrWrite;
  logic        PrRead;
  logic [31:0] PrRData;
  logic        PrStall;
  logic [1:0]  DevAddr;
  logic [31:0] DevWData;
  logic [3:0]  DevMask;
  logic        DevWE;
  logic        DevSel0;
  logic        DevSel1;
  logic [31:0] DevRData0;
  logic [31:0] DevRData1;
  logic        DevAck0;
  logic        DevAck1;
  logic        DevIrq0;
  logic        DevIrq1;
  logic [2:0]  HWInt;

  modport slave (
    input  PrAddr, PrWData, PrMask, PrWrite, PrRead,
    output PrRData, PrStall,
    output DevAddr, DevWData, DevMask, DevWE, DevSel0, DevSel1,
    input  DevRData0, DevRData1, DevAck0, DevAck1, DevIrq0, DevIrq1,
    output HWInt
  );

  modport master (
    output PrAddr, PrWData, PrMask, PrWrite, PrRead,
    input  PrRData, PrStall,
    input  DevAddr, DevWData, DevMask, DevWE, DevSel0, DevSel1,
    output DevRData0, DevRData1, DevAck0, DevAck1, DevIrq0, DevIrq1,
    input  HWInt
  );
endinterface

// File: rtl/pr_bridge.sv
// Peripheral bridge: decodes MEM-stage peripheral accesses, sequences a select/ack handshake
// with two devices, stalls the pipeline until completion, and reports timeouts/unmapped accesses.
module pr_bridge #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic       Clk,
    input logic       Rst,
    pr_bridge_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    state_t      stateNext;
    logic [7:0]  count;
    logic [31:0] result;
    logic        busErr;
    logic [15:0] errAddr;
    logic [15:0] reqAddr;
    logic [1:0]  devAddr;
    logic [31:0] devWData;
    logic [3:0]  devMask;
    logic        devWe;
    logic        devSel0;
    logic        devSel1;
    logic [2:0]  hwInt;

    logic acc;
    logic hitDev0;
    logic hitDev1;
    logic hitStat;
    logic ackSel;
    logic timeoutHit;
    logic startReq;
    logic countInc;
    logic ackDone;
    logic toDone;
    logic localDone;

    assign acc        = bus.PrRead | bus.PrWrite;
    assign hitDev0    = (bus.PrAddr[31:4] == 28'h00007f0);
    assign hitDev1    = (bus.PrAddr[31:4] == 28'h00007f1);
    assign hitStat    = (bus.PrAddr[31:2] == 30'h00001fc8);
    assign ackSel     = (devSel0 & bus.DevAck0) | (devSel1 & bus.DevAck1);
    assign timeoutHit = (count == 8'(TIMEOUT - 1));

    always_ff @(posedge Clk) begin
        if (!Rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        startReq  = 1'b0;
        countInc  = 1'b0;
        ackDone   = 1'b0;
        toDone    = 1'b0;
        localDone = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (hitDev0 | hitDev1) begin
                        stateNext = REQ;
                        startReq  = 1'b1;
                    end else begin
                        stateNext = DONE;
                        localDone = 1'b1;
                    end
                end
            end
            REQ: begin
                if (ackSel) begin
                    stateNext = DONE;
                    ackDone   = 1'b1;
                end else if (timeoutHit) begin
                    stateNext = DONE;
                    toDone    = 1'b1;
                end else begin
                    countInc = 1'b1;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            count    <= '0;
            result   <= '0;
            busErr   <= 1'b0;
            errAddr  <= '0;
            reqAddr  <= '0;
            devAddr  <= '0;
            devWData <= '0;
            devMask  <= '0;
            devWe    <= 1'b0;
            devSel0  <= 1'b0;
            devSel1  <= 1'b0;
            hwInt    <= '0;
        end else begin
            hwInt <= {busErr, bus.DevIrq1, bus.DevIrq0};
            if (startReq) begin
                devAddr  <= bus.PrAddr[3:2];
                devWData <= bus.PrWData;
                devMask  <= bus.PrMask;
                devWe    <= bus.PrWrite;
                devSel0  <= hitDev0;
                devSel1  <= hitDev1;
                count    <= '0;
                reqAddr  <= bus.PrAddr[15:0];
            end
            if (countInc) count <= count + 8'd1;
            if (ackDone) begin
                result  <= devWe ? '0 : (devSel0 ? bus.DevRData0 : bus.DevRData1);
                devSel0 <= 1'b0;
                devSel1 <= 1'b0;
                devWe   <= 1'b0;
            end
            if (toDone) begin
                result  <= '0;
                busErr  <= 1'b1;
                errAddr <= reqAddr;
                devSel0 <= 1'b0;
                devSel1 <= 1'b0;
                devWe   <= 1'b0;
            end
            // Status and unmapped accesses never touch the devices; they finish in one step.
            if (localDone) begin
                if (hitStat) begin
                    if (bus.PrRead) begin
                        result <= {busErr, 15'b0, errAddr};
                    end else begin
                        result <= '0;
                        busErr <= 1'b0;
                    end
                end else begin
                    result  <= '0;
                    busErr  <= 1'b1;
                    errAddr <= bus.PrAddr[15:0];
                end
            end
        end
    end

    assign bus.PrStall  = acc & (state != DONE) & Rst;
    assign bus.PrRData  = result;
    assign bus.DevAddr  = devAddr;
    assign bus.DevWData = devWData;
    assign bus.DevMask  = devMask;
    assign bus.DevWE    = devWe;
    assign bus.DevSel0  = devSel0;
    assign bus.DevSel1  = devSel1;
    assign bus.HWInt    = hwInt;

endmodule
